wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/load_ext.sv | 45 ++++
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: write-data select codes, load funct3 encodings and
// the layout of the write-back pipeline register.
package cpu_pkg;

  // Write-data select codes
  localparam logic [1:0] WD_RETURN_PC  = 2'b00;
  localparam logic [1:0] WD_ALU_RESULT = 2'b01;
  localparam logic [1:0] WD_MEM_DATA   = 2'b10;

  // Load funct3 encodings
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Contents of the WB pipeline register (the optional trace pc lives outside)
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        we;
    logic [4:0]  wr;
    logic [1:0]  wd_sel;
    logic [2:0]  load_type;
    logic [31:0] return_pc;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
  } wb_reg_t;

  // All-zero WB register image used by reset
  localparam wb_reg_t WB_REG_CLEAR = '{
    valid:      1'b0,
    done:       1'b0,
    we:         1'b0,
    wr:         5'd0,
    wd_sel:     2'b00,
    load_type:  3'b000,
    return_pc:  32'h0000_0000,
    alu_result: 32'h0000_0000,
    mem_data:   32'h0000_0000
  };

endpackage

// File: rtl/load_ext.sv
// Load data extension: picks the byte/half lane addressed by the low load
// address bits and sign- or zero-extends it according to funct3.
module load_ext
  import cpu_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  lane,
  input  logic [31:0] data,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; halves ignore lane[0] (misaligned halves are not split)
  always_comb begin
    byte_s = 8'h00;
    case (lane)
      2'b00:   byte_s = data[7:0];
      2'b01:   byte_s = data[15:8];
      2'b10:   byte_s = data[23:16];
      2'b11:   byte_s = data[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = data[31:16];
    end else begin
      half_s = data[15:0];
    end
  end

  // Extension by load type; unknown encodings return the raw word
  always_comb begin
    ext_data = data;
    case (load_type)
      LT_LB:   ext_data = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  ext_data = {24'h00_0000, byte_s};
      LT_LH:   ext_data = {{16{half_s[15]}}, half_s};
      LT_LHU:  ext_data = {16'h0000, half_s};
      LT_LW:   ext_data = data;
      default: ext_data = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: WB pipeline register, write-data mux with load
// extension, register-file write port, forwarding source and retired
// instruction counter. Defining WB_TRACE_EN adds the debug_wb_* trace
// ports and a stored WB pc; without it pc_i is unused.
module wb_stage
  import cpu_pkg::*;
#(
  parameter logic [1:0] RETURN_PC  = WD_RETURN_PC,
  parameter logic [1:0] ALU_RESULT = WD_ALU_RESULT,
  parameter logic [1:0] MEM_DATA   = WD_MEM_DATA
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] return_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] mem_data_i,
  input  logic [1:0]  wd_sel_i,
  input  logic [4:0]  wr_i,
  input  logic        we_i,
  input  logic [2:0]  load_type_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_wr_o,
  output logic [31:0] rf_wd_o,
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_wr_o,
  output logic [31:0] fwd_wd_o,
  output logic [63:0] instret_o
`ifdef WB_TRACE_EN
  ,
  output logic        debug_wb_have_inst_o,
  output logic [31:0] debug_wb_pc_o,
  output logic        debug_wb_ena_o,
  output logic [4:0]  debug_wb_reg_o,
  output logic [31:0] debug_wb_value_o
`endif
);

  wb_reg_t     wb_r;
  wb_reg_t     capture_s;
  logic [63:0] instret_r;
  logic [31:0] load_data_s;
  logic        retire_s;
  logic        writes_reg_s;
  logic [31:0] wd_s;

  // Snapshot of the MEM-stage inputs as they would enter the WB register
  always_comb begin
    capture_s            = WB_REG_CLEAR;
    capture_s.valid      = valid_i;
    capture_s.done       = 1'b0;
    capture_s.we         = we_i;
    capture_s.wr         = wr_i;
    capture_s.wd_sel     = wd_sel_i;
    capture_s.load_type  = load_type_i;
    capture_s.return_pc  = return_pc_i;
    capture_s.alu_result = alu_result_i;
    capture_s.mem_data   = mem_data_i;
  end

  // WB register: reset > flush (bubble) > stall (hold, mark done) > capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_r <= WB_REG_CLEAR;
    end else if (flush_i) begin
      wb_r       <= capture_s;
      wb_r.valid <= 1'b0;
    end else if (stall_i) begin
      wb_r.done <= wb_r.done | wb_r.valid;
    end else begin
      wb_r <= capture_s;
    end
  end

  // An instruction retires on its first WB cycle only
  assign retire_s     = wb_r.valid & ~wb_r.done;
  assign writes_reg_s = wb_r.valid & wb_r.we & (wb_r.wr != 5'd0);

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instret_r <= 64'd0;
    end else if (retire_s) begin
      instret_r <= instret_r + 64'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  load_ext u_load_ext (
    .load_type (wb_r.load_type),
    .lane      (wb_r.alu_result[1:0]),
    .data      (wb_r.mem_data),
    .ext_data  (load_data_s)
  );

  // Write-data select from the WB register
  always_comb begin
    wd_s = 32'h0000_0000;
    case (wb_r.wd_sel)
      RETURN_PC:  wd_s = wb_r.return_pc;
      ALU_RESULT: wd_s = wb_r.alu_result;
      MEM_DATA:   wd_s = load_data_s;
      default:    wd_s = 32'h0000_0000;
    endcase
  end

  assign rf_we_o     = writes_reg_s & ~wb_r.done;
  assign rf_wr_o     = wb_r.wr;
  assign rf_wd_o     = wd_s;
  // Forwarding stays live for the whole stall, unlike the RF write strobe
  assign fwd_valid_o = writes_reg_s;
  assign fwd_wr_o    = wb_r.wr;
  assign fwd_wd_o    = wd_s;
  assign instret_o   = instret_r;

`ifdef WB_TRACE_EN
  logic [31:0] pc_r;

  // Trace pc follows the same capture/hold/flush rules as the WB register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r <= 32'h0000_0000;
    end else if (flush_i) begin
      pc_r <= pc_i;
    end else if (stall_i) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pc_i;
    end
  end

  assign debug_wb_have_inst_o = retire_s;
  assign debug_wb_pc_o        = pc_r;
  assign debug_wb_ena_o       = rf_we_o;
  assign debug_wb_reg_o       = rf_wr_o;
  assign debug_wb_value_o     = rf_wd_o;
`else
  logic unused_pc_s;
  assign unused_pc_s = ^pc_i;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver pushes the hand-computed
// expected outputs for each cycle it drives; a monitor pops and compares
// after every rising edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_i = 32'h8000_0000;
  logic [31:0] return_pc_i = 32'h0;
  logic [31:0] alu_result_i = 32'h0;
  logic [31:0] mem_data_i = 32'h0;
  logic [1:0]  wd_sel_i = 2'b00;
  logic [4:0]  wr_i = 5'd0;
  logic        we_i = 1'b0;
  logic [2:0]  load_type_i = 3'b000;
  logic        rf_we_o, fwd_valid_o;
  logic [4:0]  rf_wr_o, fwd_wr_o;
  logic [31:0] rf_wd_o, fwd_wd_o;
  logic [63:0] instret_o;
`ifdef WB_TRACE_EN
  logic        debug_wb_have_inst_o, debug_wb_ena_o;
  logic [31:0] debug_wb_pc_o, debug_wb_value_o;
  logic [4:0]  debug_wb_reg_o;
`endif

  wb_stage dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .pc_i(pc_i), .return_pc_i(return_pc_i),
    .alu_result_i(alu_result_i), .mem_data_i(mem_data_i), .wd_sel_i(wd_sel_i),
    .wr_i(wr_i), .we_i(we_i), .load_type_i(load_type_i),
    .rf_we_o(rf_we_o), .rf_wr_o(rf_wr_o), .rf_wd_o(rf_wd_o),
    .fwd_valid_o(fwd_valid_o), .fwd_wr_o(fwd_wr_o), .fwd_wd_o(fwd_wd_o),
    .instret_o(instret_o)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_have_inst_o(debug_wb_have_inst_o), .debug_wb_pc_o(debug_wb_pc_o),
    .debug_wb_ena_o(debug_wb_ena_o), .debug_wb_reg_o(debug_wb_reg_o),
    .debug_wb_value_o(debug_wb_value_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        fv;
    logic [63:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_cycle = 0;

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  // Monitor: compare outputs after every rising edge against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we",     n_cycle, {63'd0, rf_we_o},     {63'd0, e.we});
        chk("rf_wr",     n_cycle, {59'd0, rf_wr_o},     {59'd0, e.wr});
        chk("rf_wd",     n_cycle, {32'd0, rf_wd_o},     {32'd0, e.wd});
        chk("fwd_valid", n_cycle, {63'd0, fwd_valid_o}, {63'd0, e.fv});
        chk("fwd_wr",    n_cycle, {59'd0, fwd_wr_o},    {59'd0, e.wr});
        chk("fwd_wd",    n_cycle, {32'd0, fwd_wd_o},    {32'd0, e.wd});
        chk("instret",   n_cycle, instret_o,            e.inst);
        n_cycle++;
      end
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be after the edge
  task automatic drive(input logic rst, input logic v, input logic st, input logic fl,
                       input logic [4:0] wr, input logic we, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [31:0] rpc, input logic [31:0] alu,
                       input logic [31:0] mem,
                       input logic e_we, input logic [4:0] e_wr, input logic [31:0] e_wd,
                       input logic e_fv, input logic [63:0] e_inst);
    exp_t e;
    @(negedge clk);
    reset_i = rst; valid_i = v; stall_i = st; flush_i = fl;
    wr_i = wr; we_i = we; wd_sel_i = sel; load_type_i = lt;
    return_pc_i = rpc; alu_result_i = alu; mem_data_i = mem;
    e.we = e_we; e.wr = e_wr; e.wd = e_wd; e.fv = e_fv; e.inst = e_inst;
    exp_q.push_back(e);
  endtask

  // Directed stimulus
  initial begin
    //    rst v  st fl wr     we sel    lt      rpc            alu            mem              e_we e_wr  e_wd           e_fv e_inst
    drive(1, 0, 0, 0, 5'd0,  0, 2'b00, 3'b000, 32'h0,         32'h0,         32'h0,           0, 5'd0,  32'h0,         0, 64'd0);
    drive(1, 1, 0, 0, 5'd3,  1, 2'b01, 3'b000, 32'h0,         32'h99,        32'h0,           0, 5'd0,  32'h0,         0, 64'd0);
    // ALU write-back, 1-cycle latency
    drive(0, 1, 0, 0, 5'd5,  1, 2'b01, 3'b000, 32'h0,         32'h1234,      32'h0,           1, 5'd5,  32'h1234,      1, 64'd0);
    // loads: lb lane2, lhu upper half (alu[0] ignored), lh, lbu, lw
    drive(0, 1, 0, 0, 5'd6,  1, 2'b10, 3'b000, 32'h0,         32'h2,         32'h0080_0000,   1, 5'd6,  32'hFFFF_FF80, 1, 64'd1);
    drive(0, 1, 0, 0, 5'd7,  1, 2'b10, 3'b101, 32'h0,         32'h3,         32'h8001_0000,   1, 5'd7,  32'h0000_8001, 1, 64'd2);
    drive(0, 1, 0, 0, 5'd8,  1, 2'b10, 3'b001, 32'h0,         32'h0,         32'h0000_8000,   1, 5'd8,  32'hFFFF_8000, 1, 64'd3);
    drive(0, 1, 0, 0, 5'd9,  1, 2'b10, 3'b100, 32'h0,         32'h1,         32'h0000_AB00,   1, 5'd9,  32'h0000_00AB, 1, 64'd4);
    drive(0, 1, 0, 0, 5'd10, 1, 2'b10, 3'b010, 32'h0,         32'h100,       32'hDEAD_BEEF,   1, 5'd10, 32'hDEAD_BEEF, 1, 64'd5);
    // return pc, unused select code
    drive(0, 1, 0, 0, 5'd1,  1, 2'b00, 3'b000, 32'h40,        32'h5,         32'h0,           1, 5'd1,  32'h40,        1, 64'd6);
    drive(0, 1, 0, 0, 5'd2,  1, 2'b11, 3'b000, 32'h40,        32'h5,         32'h7,           1, 5'd2,  32'h0,         1, 64'd7);
    // x0 destination, we=0, bubble
    drive(0, 1, 0, 0, 5'd0,  1, 2'b01, 3'b000, 32'h0,         32'h77,        32'h0,           0, 5'd0,  32'h77,        0, 64'd8);
    drive(0, 1, 0, 0, 5'd3,  0, 2'b01, 3'b000, 32'h0,         32'h99,        32'h0,           0, 5'd3,  32'h99,        0, 64'd9);
    drive(0, 0, 0, 0, 5'd4,  1, 2'b01, 3'b000, 32'h0,         32'h11,        32'h0,           0, 5'd4,  32'h11,        0, 64'd10);
    // stall for 3 cycles on a valid write
    drive(0, 1, 0, 0, 5'd12, 1, 2'b01, 3'b000, 32'h0,         32'hAAAA,      32'h0,           1, 5'd12, 32'hAAAA,      1, 64'd10);
    drive(0, 1, 1, 0, 5'd13, 1, 2'b01, 3'b000, 32'h0,         32'h5555,      32'h0,           0, 5'd12, 32'hAAAA,      1, 64'd11);
    drive(0, 1, 1, 0, 5'd13, 1, 2'b01, 3'b000, 32'h0,         32'h5555,      32'h0,           0, 5'd12, 32'hAAAA,      1, 64'd11);
    drive(0, 1, 1, 0, 5'd13, 1, 2'b01, 3'b000, 32'h0,         32'h5555,      32'h0,           0, 5'd12, 32'hAAAA,      1, 64'd11);
    drive(0, 0, 0, 0, 5'd0,  0, 2'b01, 3'b000, 32'h0,         32'h0,         32'h0,           0, 5'd0,  32'h0,         0, 64'd11);
    // stall and flush on the same edge: flush wins
    drive(0, 1, 0, 0, 5'd14, 1, 2'b01, 3'b000, 32'h0,         32'h1414,      32'h0,           1, 5'd14, 32'h1414,      1, 64'd11);
    drive(0, 1, 1, 1, 5'd14, 1, 2'b01, 3'b000, 32'h0,         32'h1414,      32'h0,           0, 5'd14, 32'h1414,      0, 64'd12);
    // reset in the middle of a stall
    drive(0, 1, 0, 0, 5'd15, 1, 2'b01, 3'b000, 32'h0,         32'h1515,      32'h0,           1, 5'd15, 32'h1515,      1, 64'd12);
    drive(0, 1, 1, 0, 5'd15, 1, 2'b01, 3'b000, 32'h0,         32'h1515,      32'h0,           0, 5'd15, 32'h1515,      1, 64'd13);
    drive(1, 1, 1, 1, 5'd15, 1, 2'b01, 3'b000, 32'h0,         32'h1515,      32'h0,           0, 5'd0,  32'h0,         0, 64'd0);
    drive(0, 0, 0, 0, 5'd0,  0, 2'b01, 3'b000, 32'h0,         32'h0,         32'h0,           0, 5'd0,  32'h0,         0, 64'd0);
    // counter wrap: preload all-ones, then retire one instruction
    @(negedge clk);
    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_r;
    drive(0, 1, 0, 0, 5'd16, 1, 2'b01, 3'b000, 32'h0,         32'h1616,      32'h0,           1, 5'd16, 32'h1616,      1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(0, 0, 0, 0, 5'd0,  0, 2'b01, 3'b000, 32'h0,         32'h0,         32'h0,           0, 5'd0,  32'h0,         0, 64'd0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) begin
        @(negedge clk);
      end
    end
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
